// File: rtl/vga_pkg.sv
// Shared VGA timing defaults: 640x480@60 constants, counter width, sync polarity
// encodings and a helper to total up a timing axis.
package vga_pkg;

  localparam int VGA_CNT_W    = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  // Length of one axis (pixels per line or lines per frame).
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-clock enable: divides clk by CLK_DIV and emits a registered 1-clk
// pulse per pixel period. The first pulse appears CLK_DIV clocks after reset
// is released; with CLK_DIV=1 the pulse stays high continuously.
module vga_pix_tick
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int            DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // Next divider count; the tick is raised for the period following the terminal count.
  always_comb begin
    tick_d = (div_q == DIV_LAST);
    div_d  = tick_d ? '0 : div_q + DIV_W'(1);
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign pix_tick = tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Generic VGA timing generator. Stage 0 holds the pixel coordinates and the
// active-video flag; stage 1 holds the pin-facing colour and sync levels, one
// pixel behind stage 0 so colour and syncs always leave the chip together.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int RGB_W    = 3,
  parameter int CNT_W    = VGA_CNT_W,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit H_POL    = POL_ACTIVE_LOW,
  parameter bit V_POL    = POL_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             pix_tick,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic [RGB_W-1:0] rgb,
  output logic             hsync,
  output logic             vsync
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // Window bounds held one bit wider than the counters so parameter sums never wrap.
  localparam logic [CNT_W:0] H_ACT_X  = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] V_ACT_X  = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] HS_BEG_X = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_END_X = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG_X = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_END_X = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
  end

  logic             tick;
  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic             video_on_q, video_on_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [CNT_W:0]   h_x, v_x, h_x_d, v_x_d;
  logic             h_last, v_last, hs_win, vs_win;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (tick)
  );

  // Decode the current stage-0 position.
  always_comb begin
    h_x    = {1'b0, hcount_q};
    v_x    = {1'b0, vcount_q};
    h_last = (hcount_q == H_LAST);
    v_last = (vcount_q == V_LAST);
    hs_win = (h_x >= HS_BEG_X) && (h_x < HS_END_X);
    vs_win = (v_x >= VS_BEG_X) && (v_x < VS_END_X);
  end

  // Next state: counters and stage 1 move on pixel ticks only; video_on tracks the next counters.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    if (tick) begin
      hcount_d = h_last ? '0 : hcount_q + CNT_W'(1);
      if (h_last) begin
        vcount_d = v_last ? '0 : vcount_q + CNT_W'(1);
      end
      rgb_d   = video_on_q ? rgb_in : '0;
      hsync_d = hs_win ? H_POL : ~H_POL;
      vsync_d = vs_win ? V_POL : ~V_POL;
    end
    h_x_d      = {1'b0, hcount_d};
    v_x_d      = {1'b0, vcount_d};
    video_on_d = (h_x_d < H_ACT_X) && (v_x_d < V_ACT_X);
  end

  // Stage-0 and stage-1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q   <= '0;
      vcount_q   <= '0;
      video_on_q <= 1'b0;
      rgb_q      <= '0;
      hsync_q    <= ~H_POL;
      vsync_q    <= ~V_POL;
    end else begin
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      video_on_q <= video_on_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign pix_tick    = tick;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign video_on    = video_on_q;
  assign line_start  = tick && (hcount_q == '0);
  assign frame_start = line_start && (vcount_q == '0);
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-timing instance (12x7, CLK_DIV=2),
// a small-timing active-high instance with CLK_DIV=1, and a default 640x480 instance.
module tb_vga_timing_gen;

  localparam int AW = 5;
  localparam int BW = 4;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0]    rgb_in_a = 3'd0, rgb_in_b = 3'd0, rgb_in_d = 3'd0;
  logic          pix_tick_a, line_start_a, frame_start_a, video_on_a, hsync_a, vsync_a;
  logic          pix_tick_b, line_start_b, frame_start_b, video_on_b, hsync_b, vsync_b;
  logic          pix_tick_d, line_start_d, frame_start_d, video_on_d, hsync_d, vsync_d;
  logic [AW-1:0] hcount_a, vcount_a;
  logic [BW-1:0] hcount_b, vcount_b;
  logic [DW-1:0] hcount_d, vcount_d;
  logic [2:0]    rgb_a, rgb_b, rgb_d;

  vga_timing_gen #(
    .CLK_DIV(2), .RGB_W(3), .CNT_W(AW),
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .rgb_in(rgb_in_a), .pix_tick(pix_tick_a),
    .hcount(hcount_a), .vcount(vcount_a), .video_on(video_on_a),
    .line_start(line_start_a), .frame_start(frame_start_a),
    .rgb(rgb_a), .hsync(hsync_a), .vsync(vsync_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .RGB_W(3), .CNT_W(BW),
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .rgb_in(rgb_in_b), .pix_tick(pix_tick_b),
    .hcount(hcount_b), .vcount(vcount_b), .video_on(video_on_b),
    .line_start(line_start_b), .frame_start(frame_start_b),
    .rgb(rgb_b), .hsync(hsync_b), .vsync(vsync_b)
  );

  vga_timing_gen u_d (
    .clk(clk), .rst(rst), .rgb_in(rgb_in_d), .pix_tick(pix_tick_d),
    .hcount(hcount_d), .vcount(vcount_d), .video_on(video_on_d),
    .line_start(line_start_d), .frame_start(frame_start_d),
    .rgb(rgb_d), .hsync(hsync_d), .vsync(vsync_d)
  );

  task automatic test_reset();
    int lat_a, lat_b, lat_d;
    rst = 1'b1;
    rgb_in_a = 3'b101;
    rgb_in_b = 3'b011;
    rgb_in_d = 3'b110;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({hcount_a, vcount_a, rgb_a, hsync_a, vsync_a, pix_tick_a, line_start_a, frame_start_a, video_on_a}
          !== {5'd0, 5'd0, 3'd0, 1'b1, 1'b1, 4'b0000}) begin
        n_err++;
        $display("FAIL reset_a cycle %0d got h=%0d v=%0d rgb=%0d hs=%b vs=%b tick=%b ls=%b fs=%b vo=%b want all 0, hs=vs=1",
                 i, hcount_a, vcount_a, rgb_a, hsync_a, vsync_a, pix_tick_a, line_start_a, frame_start_a, video_on_a);
      end
    end
    n_vec++;
    if ({hcount_b, vcount_b, rgb_b, hsync_b, vsync_b, pix_tick_b, line_start_b, frame_start_b, video_on_b}
        !== {4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_b got h=%0d v=%0d rgb=%0d hs=%b vs=%b tick=%b want all 0 (active-high syncs idle 0)",
               hcount_b, vcount_b, rgb_b, hsync_b, vsync_b, pix_tick_b);
    end
    n_vec++;
    if ({hcount_d, vcount_d, rgb_d, hsync_d, vsync_d, pix_tick_d, line_start_d, frame_start_d, video_on_d}
        !== {10'd0, 10'd0, 3'd0, 1'b1, 1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_d got h=%0d v=%0d rgb=%0d hs=%b vs=%b tick=%b want all 0, hs=vs=1",
               hcount_d, vcount_d, rgb_d, hsync_d, vsync_d, pix_tick_d);
    end
    rst = 1'b0;
    lat_a = 0; lat_b = 0; lat_d = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (pix_tick_a && lat_a == 0) lat_a = n;
      if (pix_tick_b && lat_b == 0) lat_b = n;
      if (pix_tick_d && lat_d == 0) lat_d = n;
    end
    n_vec++;
    if (lat_a != 2) begin n_err++; $display("FAIL first_tick_a got %0d clk want 2", lat_a); end
    n_vec++;
    if (lat_b != 1) begin n_err++; $display("FAIL first_tick_b got %0d clk want 1", lat_b); end
    n_vec++;
    if (lat_d != 2) begin n_err++; $display("FAIL first_tick_d got %0d clk want 2", lat_d); end
  endtask

  task automatic test_line_timing();
    bit   found;
    int   period, lows, first_low_h, last_h, start_v;
    logic vo639, vo640;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (line_start_d) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL line_align_d got no line_start want one within 2000 clk"); end
    start_v = int'(vcount_d);
    found = 1'b0; period = 0; lows = 0; first_low_h = -1; last_h = -1;
    vo639 = 1'bx; vo640 = 1'bx;
    for (int i = 1; i <= 2000 && !found; i++) begin
      @(negedge clk);
      if (hsync_d === 1'b0 && first_low_h < 0) first_low_h = int'(hcount_d);
      if (pix_tick_d && hsync_d === 1'b0) lows++;
      if (hcount_d == 10'd639) vo639 = video_on_d;
      if (hcount_d == 10'd640) vo640 = video_on_d;
      if (line_start_d) begin
        found  = 1'b1;
        period = i;
      end else if (pix_tick_d) begin
        last_h = int'(hcount_d);
      end
    end
    n_vec++;
    if (period != 1600) begin n_err++; $display("FAIL line_period_d got %0d clk want 1600", period); end
    n_vec++;
    if (lows != 96) begin n_err++; $display("FAIL hsync_width_d got %0d ticks want 96", lows); end
    n_vec++;
    if (first_low_h != 657) begin n_err++; $display("FAIL hsync_fall_d got hcount %0d want 657", first_low_h); end
    n_vec++;
    if (last_h != 799) begin n_err++; $display("FAIL hwrap_d got last hcount %0d want 799", last_h); end
    n_vec++;
    if (int'(vcount_d) != start_v + 1) begin
      n_err++; $display("FAIL vstep_d got vcount %0d want %0d", vcount_d, start_v + 1);
    end
    n_vec++;
    if ({vo639, vo640} !== 2'b10) begin
      n_err++; $display("FAIL video_on_edge_d got %b%b want 10", vo639, vo640);
    end
  endtask

  task automatic test_frame_timing();
    bit found;
    int period, vs_lows, hs_lows, fl_h, fl_v, last_h, last_v;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (frame_start_a) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL frame_align_a got no frame_start want one within 400 clk"); end
    found = 1'b0; period = 0; vs_lows = 0; hs_lows = 0;
    fl_h = -1; fl_v = -1; last_h = -1; last_v = -1;
    for (int i = 1; i <= 400 && !found; i++) begin
      @(negedge clk);
      if (vsync_a === 1'b0 && fl_h < 0) begin fl_h = int'(hcount_a); fl_v = int'(vcount_a); end
      if (pix_tick_a && vsync_a === 1'b0) vs_lows++;
      if (pix_tick_a && hsync_a === 1'b0) hs_lows++;
      if (frame_start_a) begin
        found  = 1'b1;
        period = i;
      end else if (pix_tick_a) begin
        last_h = int'(hcount_a);
        last_v = int'(vcount_a);
      end
    end
    n_vec++;
    if (period != 168) begin n_err++; $display("FAIL frame_period_a got %0d clk want 168", period); end
    n_vec++;
    if (vs_lows != 12) begin n_err++; $display("FAIL vsync_width_a got %0d ticks want 12", vs_lows); end
    n_vec++;
    if (hs_lows != 14) begin n_err++; $display("FAIL hsync_per_frame_a got %0d ticks want 14", hs_lows); end
    n_vec++;
    if (fl_h != 1 || fl_v != 5) begin
      n_err++; $display("FAIL vsync_fall_a got (%0d,%0d) want (1,5)", fl_h, fl_v);
    end
    n_vec++;
    if (last_h != 11 || last_v != 6) begin
      n_err++; $display("FAIL frame_wrap_a got last (%0d,%0d) want (11,6)", last_h, last_v);
    end
  endtask

  task automatic test_blanking();
    bit         found;
    int         ticks, sevens, zeros, cur_h, cur_v, ph, pv;
    logic [2:0] exp_rgb;
    rgb_in_a = 3'b111;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (frame_start_a) found = 1'b1;
    end
    ticks = 0; sevens = 0; zeros = 0;
    for (int i = 0; i < 400 && ticks < 84; i++) begin
      @(negedge clk);
      if (pix_tick_a) begin
        ticks++;
        if (rgb_a === 3'b111) sevens++;
        if (rgb_a === 3'b000) zeros++;
      end
    end
    n_vec++;
    if (sevens != 32 || zeros != 52) begin
      n_err++; $display("FAIL blank_const_a got %0d lit / %0d dark want 32 / 52", sevens, zeros);
    end
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (frame_start_a) found = 1'b1;
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL blank_align_a got no frame_start want one within 400 clk"); end
    rgb_in_a = hcount_a[2:0];
    cur_h = 0; cur_v = 0; ticks = 0;
    for (int i = 0; i < 400 && ticks < 84; i++) begin
      @(negedge clk);
      if (pix_tick_a) begin
        ticks++;
        ph = cur_h; pv = cur_v;
        cur_h++;
        if (cur_h == 12) begin
          cur_h = 0;
          cur_v = (cur_v == 6) ? 0 : cur_v + 1;
        end
        exp_rgb = (ph < 8 && pv < 4) ? 3'(ph) : 3'd0;
        n_vec++;
        if ({hcount_a, vcount_a, rgb_a} !== {5'(cur_h), 5'(cur_v), exp_rgb}) begin
          n_err++;
          $display("FAIL pixel_pipe_a got (%0d,%0d) rgb=%0d want (%0d,%0d) rgb=%0d",
                   hcount_a, vcount_a, rgb_a, cur_h, cur_v, exp_rgb);
        end
      end
      rgb_in_a = hcount_a[2:0];
    end
  endtask

  task automatic test_midframe_reset();
    bit found;
    rgb_in_a = 3'b111;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (hcount_a == 5'd5 && vcount_a == 5'd2) found = 1'b1;
    end
    n_vec++;
    if (!found || rgb_a !== 3'b111) begin
      n_err++; $display("FAIL midframe_setup_a got found=%0d rgb=%0d want 1 and 7", found, rgb_a);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({hcount_a, vcount_a, rgb_a, hsync_a, vsync_a, pix_tick_a, line_start_a, frame_start_a, video_on_a}
        !== {5'd0, 5'd0, 3'd0, 1'b1, 1'b1, 4'b0000}) begin
      n_err++;
      $display("FAIL midframe_reset_a got h=%0d v=%0d rgb=%0d hs=%b vs=%b tick=%b ls=%b fs=%b vo=%b want reset values",
               hcount_a, vcount_a, rgb_a, hsync_a, vsync_a, pix_tick_a, line_start_a, frame_start_a, video_on_a);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (pix_tick_a) found = 1'b1;
    end
    n_vec++;
    if (!found || {frame_start_a, line_start_a, hcount_a, vcount_a} !== {1'b1, 1'b1, 5'd0, 5'd0}) begin
      n_err++;
      $display("FAIL restart_a got tick=%0d fs=%b ls=%b (%0d,%0d) want fs=1 ls=1 (0,0)",
               found, frame_start_a, line_start_a, hcount_a, vcount_a);
    end
  endtask

  task automatic test_params();
    bit found;
    int ticks, period, hs_hi, vs_hi, lines;
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pix_tick_b === 1'b1) ticks++;
    end
    n_vec++;
    if (ticks != 30) begin n_err++; $display("FAIL tick_every_clk_b got %0d of 30 want 30", ticks); end
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (frame_start_b) found = 1'b1;
    end
    found = 1'b0; period = 0; hs_hi = 0; vs_hi = 0; lines = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      if (pix_tick_b && hsync_b === 1'b1) hs_hi++;
      if (pix_tick_b && vsync_b === 1'b1) vs_hi++;
      if (line_start_b) lines++;
      if (frame_start_b) begin
        found  = 1'b1;
        period = i;
      end
    end
    n_vec++;
    if (period != 84) begin n_err++; $display("FAIL frame_period_b got %0d clk want 84", period); end
    n_vec++;
    if (hs_hi != 14) begin n_err++; $display("FAIL hsync_high_b got %0d ticks want 14", hs_hi); end
    n_vec++;
    if (vs_hi != 12) begin n_err++; $display("FAIL vsync_high_b got %0d ticks want 12", vs_hi); end
    n_vec++;
    if (lines != 7) begin n_err++; $display("FAIL lines_per_frame_b got %0d want 7", lines); end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_blanking();
    test_midframe_reset();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
